// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// master drives operands and out_ready; slave is the adder.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, x, y, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, x, y, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: one CHUNK-bit slice per clock with a registered carry.
// Subtract is folded in at acceptance by inverting y and the carry-in.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// CALC  | adding chunk k each edge, k = 0 .. N-1
// DONE  | out_valid=1, result held until out_ready
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic            clk,
  input logic            rst,
  seq_chunk_adder_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_param_check
    $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              carry_q, c_out_q, ovf_q;
  logic [KW-1:0]     k_q;
  logic              last_chunk;
  logic [CHUNK-1:0]  a_k, b_k, s_k;
  logic              c_k_out, c_top_in;

  assign a_k        = a_q[int'(k_q)*CHUNK +: CHUNK];
  assign b_k        = b_q[int'(k_q)*CHUNK +: CHUNK];
  assign {c_k_out, s_k} = {1'b0, a_k} + {1'b0, b_k} + (CHUNK+1)'(carry_q);
  // carry into the chunk MSB recovered from the MSB sum bit
  assign c_top_in   = a_k[CHUNK-1] ^ b_k[CHUNK-1] ^ s_k[CHUNK-1];
  assign last_chunk = (k_q == KW'(N-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.x;
            b_q     <= bus.sub ? ~bus.y : bus.y;
            carry_q <= bus.c_in ^ bus.sub;
            k_q     <= '0;
          end
        end
        CALC: begin
          sum_q[int'(k_q)*CHUNK +: CHUNK] <= s_k;
          carry_q <= c_k_out;
          k_q     <= k_q + 1'b1;
          if (last_chunk) begin
            c_out_q <= c_k_out;
            ovf_q   <= c_k_out ^ c_top_in;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;
endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Parametrised, multi-cycle successor to the team's fixed 16-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands one CHUNK-bit slice per clock, carrying between slices in a register. A valid/ready handshake sits on both the operand side and the result side. It also reports signed overflow and supports a subtract mode. It is the area-lean arithmetic unit for datapaths where a full-width single-cycle carry chain is unwanted.

## Interface
- WIDTH, 16: operand and result width in bits; must be an integer multiple of CHUNK (elaboration error otherwise).
- CHUNK, 4: bits processed per clock. N = WIDTH/CHUNK is the number of chunk cycles.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- in_valid  input  1  operands x, y, c_in, sub are valid.
- in_ready  output  1  block can accept operands.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- c_in  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of MSB (in sub mode: 1 = no borrow).
- overflow  output  1  two's-complement signed overflow.

## Operation
- Result definition: sum, c_out = x + (sub ? ~y : y) + (c_in ^ sub), at WIDTH+1 bits.
  - sub=1, c_in=0 gives x − y.
  - sub=1, c_in=1 gives x − y − 1.
- overflow = carry into MSB XOR carry out of MSB.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1, out_valid=0. On in_valid && in_ready, register x, y (pre-inverted if sub), and the initial carry c_in^sub. Clear the chunk index k=0. Go to CALC.
- CALC: in_ready=0, out_valid=0. Each edge:
  - Add chunk k of the registered operands plus the carry register.
  - Write sum[k*CHUNK +: CHUNK] and update the carry.
  - Increment k.
  - On the edge processing k=N−1: latch c_out and overflow (from the top chunk's MSB carry-in/carry-out), then go to DONE.
- DONE: out_valid=1; sum, c_out, overflow held stable. On out_ready && out_valid, go to IDLE.
- Inputs x, y, c_in, sub are sampled only on the acceptance edge. Later changes have no effect.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- sum, c_out, overflow are don't-care while out_valid=0, apart from their reset values.

## Timing
- Reset (rst=1 at an edge): state=IDLE, k=0, carry=0, sum=0, c_out=0, overflow=0, out_valid=0, in_ready=1 from the following cycle.
- Reset is effective in any state. Mid-CALC or in DONE it aborts the operation and no result is presented.
- Latency: with acceptance at edge t0, chunks are processed at edges t0+1 … t0+N. out_valid is high from edge t0+N (N clocks after acceptance).
- Result handshake at edge t1 gives out_valid=0 and in_ready=1 from t1. Next acceptance is earliest at t1+1.
- Minimum issue interval: N+1 clocks with out_ready tied high.
- Back-pressure: DONE persists indefinitely while out_ready=0. Outputs are held bit-stable.
- rst and in_valid high on the same edge: reset wins, nothing is accepted.
- N=1 (CHUNK=WIDTH) is legal. CALC then lasts one edge.

## Test plan
- WIDTH=16/CHUNK=4, add x=0x1234, y=0x4321, c_in=0 → sum=0x5555, c_out=0, overflow=0; out_valid rises exactly 4 edges after acceptance; in_ready=0 throughout.
- Add x=0xFFFF, y=0x0001, c_in=0 → sum=0x0000, c_out=1, overflow=0. Add x=0x7FFF, y=0x0001 → sum=0x8000, c_out=0, overflow=1.
- Sub x=0x0005, y=0x0007, c_in=0 → sum=0xFFFE, c_out=0, overflow=0. Sub x=0x8000, y=0x0001 → sum=0x7FFF, c_out=1, overflow=1.
- Back-pressure: out_ready=0 for 5 cycles after out_valid, with new in_valid pulses and x/y toggling.
  - Required: sum/c_out/overflow unchanged, in_ready=0, the extra input is not accepted.
  - Handshake on cycle 6 → in_ready=1 the next cycle.
- rst=1 for one edge after 2 chunk edges of CALC → out_valid=0, sum=0, in_ready=1. A following add 0x00FF+0x0001 yields sum=0x0100, c_out=0 after 4 edges.
- Parameter sweep (WIDTH=32/CHUNK=8, WIDTH=8/CHUNK=8, WIDTH=16/CHUNK=1): 1000 random operands/modes with random out_ready stalls.
  - Required: every result matches the behavioural model.
  - Required: latency equals N; no result is lost or duplicated.
